// File: rtl/axis_img_packer_if.sv
// Pixel-stream input and packed-image output bundle of axis_img_packer.
// slave = packer side, master = upstream DMA / downstream classifier side.
interface axis_img_packer_if #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 121
);
  localparam int IMG_W = PIX_W * N_PIX;

  logic [PIX_W-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [IMG_W-1:0] img_out;
  logic             valid_out;
  logic             ready_in;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, ready_in,
    output s_axis_tready, img_out, valid_out
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, ready_in,
    input  s_axis_tready, img_out, valid_out
  );
endinterface

// File: rtl/axis_img_packer.sv
// Packs N_PIX-beat AXI-Stream pixel frames into one image word; drops malformed frames.
// Optional PACKER_PINGPONG_EN: separate output register so the next frame fills while one is pending.
module axis_img_packer #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 121,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  axis_img_packer_if.slave bus,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int IMG_W = PIX_W * N_PIX;
  localparam int IDX_W = $clog2(N_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

`ifdef PACKER_PINGPONG_EN
  // HOLD: shift register holds a complete frame waiting for the output register to free up
  typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;
`else
  typedef enum logic [1:0] {FILL, DRAIN, FULL} state_t;
`endif

  state_t           state, nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [IMG_W-1:0] shift_reg, packed_nxt;
  logic             beat, out_hs, last_idx, err_nxt;

  assign beat       = bus.s_axis_tvalid && bus.s_axis_tready;
  assign out_hs     = bus.valid_out && bus.ready_in;
  assign last_idx   = (cnt == LAST_IDX);
  assign packed_nxt = {shift_reg[IMG_W-PIX_W-1:0], bus.s_axis_tdata};

`ifdef PACKER_PINGPONG_EN
  logic             out_full, load_out;
  logic [IMG_W-1:0] img_q, load_src;

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    err_nxt  = 1'b0;
    load_out = 1'b0;
    load_src = packed_nxt;
    case (state)
      FILL: if (beat) begin
        if (last_idx) begin
          cnt_nxt = '0;
          if (bus.s_axis_tlast) begin
            if (!out_full || out_hs) load_out = 1'b1;
            else                     nxt      = HOLD;
          end else begin
            err_nxt = 1'b1;
            nxt     = DRAIN;
          end
        end else if (bus.s_axis_tlast) begin
          err_nxt = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: if (beat && bus.s_axis_tlast) nxt = FILL;
      HOLD: if (out_hs) begin
        nxt      = FILL;
        load_out = 1'b1;
        load_src = shift_reg;
      end
      default: nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FILL;
      cnt       <= '0;
      shift_reg <= '0;
      img_q     <= '0;
      out_full  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
      if (beat && state == FILL) shift_reg <= packed_nxt;
      // a reload in the handshake cycle keeps the output full with the next frame
      if (load_out) begin
        img_q    <= load_src;
        out_full <= 1'b1;
      end else if (out_hs) begin
        out_full <= 1'b0;
      end
      if (out_hs) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign bus.s_axis_tready = (state != HOLD);
  assign bus.valid_out     = out_full;
  assign bus.img_out       = img_q;
`else
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    err_nxt = 1'b0;
    case (state)
      FILL: if (beat) begin
        if (last_idx) begin
          cnt_nxt = '0;
          if (bus.s_axis_tlast) nxt = FULL;
          else begin
            err_nxt = 1'b1;
            nxt     = DRAIN;
          end
        end else if (bus.s_axis_tlast) begin
          err_nxt = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: if (beat && bus.s_axis_tlast) nxt = FILL;
      FULL:  if (out_hs) nxt = FILL;
      default: nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FILL;
      cnt       <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
      if (beat && state == FILL) shift_reg <= packed_nxt;
      if (out_hs) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // shift register doubles as the output; it cannot move in FULL since tready is low
  assign bus.s_axis_tready = (state != FULL);
  assign bus.valid_out     = (state == FULL);
  assign bus.img_out       = shift_reg;
`endif
endmodule

// File: tb/tb_axis_img_packer.sv
// Random + directed scoreboard bench for axis_img_packer: stimulus pushes expected images,
// a monitor pops and compares on every output handshake.
module tb_axis_img_packer;
  localparam int PIX_W = 8;
  localparam int N_PIX = 121;
  localparam int CNT_W = 16;
  localparam int IMG_W = PIX_W * N_PIX;
  localparam int TMO   = 3000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;

  axis_img_packer_if #(.PIX_W(PIX_W), .N_PIX(N_PIX)) bus ();

  axis_img_packer #(.PIX_W(PIX_W), .N_PIX(N_PIX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int err_exp = 0, err_seen = 0, delivered = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic [IMG_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [IMG_W-1:0] act,
                           input logic [IMG_W-1:0] exp);
    int bad = -1;
    vectors++;
    for (int i = 0; i < N_PIX; i++)
      if (bad < 0 && act[IMG_W-1-PIX_W*i -: PIX_W] !== exp[IMG_W-1-PIX_W*i -: PIX_W]) bad = i;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s: pixel %0d got %02h expected %02h", name, bad,
               act[IMG_W-1-PIX_W*bad -: PIX_W], exp[IMG_W-1-PIX_W*bad -: PIX_W]);
    end
  endtask

  initial begin
    bus.ready_in = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.ready_in = 1'b0;
        1:       bus.ready_in = 1'b1;
        default: bus.ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: samples mid-cycle, scores every output handshake
  initial begin
    logic [IMG_W-1:0] prev_img = '0;
    logic             prev_v   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        delivered = 0;
        prev_v    = 1'b0;
        exp_q.delete();
      end else begin
        if (frame_err === 1'b1) err_seen++;
        if (bus.valid_out && prev_v) check_img("img_stable", bus.img_out, prev_img);
`ifndef PACKER_PINGPONG_EN
        if (bus.valid_out) check("tready_low_while_valid", 32'(bus.s_axis_tready), 0);
`endif
        if (bus.valid_out && bus.ready_in) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got valid_out=1 expected no frame");
          end else begin
            check_img("img", bus.img_out, exp_q.pop_front());
          end
          check("frame_cnt_at_hs", 32'(frame_cnt), 32'(CNT_W'(delivered)));
          delivered++;
        end
        prev_v   = bus.valid_out && !bus.ready_in;
        prev_img = bus.img_out;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, output int waited);
    waited = 0;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    while (!bus.s_axis_tready && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= TMO) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got tready=0 for %0d cycles expected acceptance", waited);
    end
    @(posedge clk);
    #1 bus.s_axis_tvalid = 1'b0;
  endtask

  // kind: 0 counting, 1 all 8'hA5, 2 random; tlast always on the final beat
  task automatic send_frame(input int len, input int kind, input bit gaps, output int max_wait);
    logic [IMG_W-1:0] img = '0;
    logic [7:0] d;
    int w;
    max_wait = 0;
    for (int i = 0; i < len; i++) begin
      d = (kind == 0) ? 8'(i) : (kind == 1) ? 8'hA5 : 8'($urandom);
      if (i < N_PIX) img[IMG_W-1-PIX_W*i -: PIX_W] = d;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      send_beat(d, i == len - 1, w);
      if (w > max_wait) max_wait = w;
    end
    if (len == N_PIX) exp_q.push_back(img);
    else              err_exp++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && n < TMO) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= TMO) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got %0d frames pending expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int w, e0, len, r;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check_img("rst_img", bus.img_out, '0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("tready_after_rst", 32'(bus.s_axis_tready), 1);

    // counting frame, ready high
    rdy_mode = 1;
    send_frame(N_PIX, 0, 1'b0, w);
    check("t1_latency", 32'(bus.valid_out), 1);
    check("t1_first_pix", 32'(bus.img_out[967:960]), 32'h00);
    check("t1_pix119", 32'(bus.img_out[15:8]), 32'h77);
    check("t1_last_pix", 32'(bus.img_out[7:0]), 32'h78);
    wait_idle();
    check("t1_frame_cnt", 32'(frame_cnt), 1);
    check("t1_no_err", 32'(err_seen), 0);

    // backpressure
    rdy_mode = 0;
    send_frame(N_PIX, 2, 1'b1, w);
    repeat (20) begin
      @(negedge clk);
      #1 check("t2_valid_held", 32'(bus.valid_out), 1);
`ifndef PACKER_PINGPONG_EN
      check("t2_tready_low", 32'(bus.s_axis_tready), 0);
`endif
    end
    rdy_mode = 1;
    wait_idle();
    check("t2_tready_back", 32'(bus.s_axis_tready), 1);
    check("t2_frame_cnt", 32'(frame_cnt), 2);

    // short frame then all-A5 frame
    e0 = err_seen;
    send_frame(50, 0, 1'b0, w);
    repeat (3) @(negedge clk);
    #1 check("t3_err_pulse", 32'(err_seen), 32'(e0 + 1));
    check("t3_no_valid", 32'(bus.valid_out), 0);
    send_frame(N_PIX, 1, 1'b0, w);
    wait_idle();

    // long frame then good frame
    e0 = err_seen;
    send_frame(130, 2, 1'b1, w);
    repeat (3) @(negedge clk);
    #1 check("t4_err_pulse", 32'(err_seen), 32'(e0 + 1));
    check("t4_no_valid", 32'(bus.valid_out), 0);
    send_frame(N_PIX, 2, 1'b1, w);
    wait_idle();
    check("t4_frame_cnt", 32'(frame_cnt), 4);

    // reset after 60 beats of a frame
    for (int i = 0; i < 60; i++) send_beat(8'($urandom), 1'b0, w);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_valid", 32'(bus.valid_out), 0);
    check("t5_err", 32'(frame_err), 0);
    check("t5_cnt", 32'(frame_cnt), 0);
    check_img("t5_img", bus.img_out, '0);
    @(negedge clk) rst = 1'b1;
    send_frame(N_PIX, 2, 1'b1, w);
    wait_idle();
    check("t5_frame_cnt", 32'(frame_cnt), 1);

    // random frames, random ready
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      r = $urandom_range(0, 9);
      len = (r < 7) ? N_PIX : (r < 9) ? $urandom_range(1, N_PIX - 1) : $urandom_range(N_PIX + 1, 140);
      send_frame(len, 2, 1'b1, w);
    end
    rdy_mode = 1;
    wait_idle();
    check("rand_frame_cnt", 32'(frame_cnt), 32'(CNT_W'(delivered)));

`ifdef PACKER_PINGPONG_EN
    // A pending on output, B fills behind it without stalling
    rdy_mode = 0;
    e0 = delivered;
    send_frame(N_PIX, 2, 1'b0, w);
    send_frame(N_PIX, 2, 1'b0, w);
    check("pp_b_no_stall", 32'(w), 0);
    check("pp_tready_low", 32'(bus.s_axis_tready), 0);
    check("pp_valid", 32'(bus.valid_out), 1);
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    wait_idle();
    check("pp_two_delivered", 32'(delivered), 32'(e0 + 2));
    check("pp_tready_back", 32'(bus.s_axis_tready), 1);
`endif

    repeat (3) @(negedge clk);
    check("err_count", 32'(err_seen), 32'(err_exp));
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_img_packer.md
Name: axis_img_packer

Overview:
- Upstream stage of the TCB classifier top. Receives 8-bit pixels one per beat from the PS/DMA AXI-Stream.
- Assembles each 121-pixel frame (11x11) into one 968-bit image vector.
- Presents the vector to the classifier's img_source/valid_top/ready_top interface with a valid/ready handshake.
- Detects malformed frames (wrong length versus tlast) and drops them.

Parameters:
PIX_W, 8, bits per pixel
N_PIX, 121, pixels per frame; IMG_W = PIX_W*N_PIX (968) is a derived localparam
CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
s_axis_tdata  in  PIX_W  pixel beat
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accept
s_axis_tlast  in  1  last pixel of frame
img_out  out  IMG_W  packed image, drives classifier img_source
valid_out  out  1  image valid, drives valid_top
ready_in  in  1  classifier ready, driven by ready_top
frame_err  out  1  one-cycle pulse on malformed frame
frame_cnt  out  CNT_W  count of delivered frames

Behaviour:
- Reset:
  - rst sampled low at a clk edge: state=FILL, pixel count=0, img_out=0, valid_out=0, frame_err=0, frame_cnt=0.
  - s_axis_tready=1 from the first cycle after reset release.
  - Reset mid-frame discards the partial frame and any pending output.
- Beat accepted when s_axis_tvalid && s_axis_tready.
- Packing:
  - On each accepted beat in FILL: shift_reg <= {shift_reg[IMG_W-PIX_W-1:0], tdata}; count++.
  - First pixel of the frame ends at [IMG_W-1:IMG_W-PIX_W]; last pixel at [PIX_W-1:0].
- States:
  - FILL: tready=1.
    - Accepted beat, count<N_PIX-1, tlast=1 (short frame): frame_err pulses next cycle; count<=0; stay FILL; nothing delivered.
    - Accepted beat, count==N_PIX-1, tlast=1: go FULL; valid_out=1 the next cycle (latency 1 clk after the last beat); img_out = packed frame; count<=0.
    - Accepted beat, count==N_PIX-1, tlast=0 (long frame): frame_err pulses next cycle; frame discarded; go DRAIN.
  - DRAIN: tready=1; accepted beats are dropped; the beat with tlast=1 returns the block to FILL with count=0.
  - FULL: valid_out=1; tready=0; img_out held stable. On valid_out && ready_in: valid_out=0 next cycle; frame_cnt++ (wraps all-ones to 0); go FILL; tready=1 next cycle.
- valid_out is never withdrawn before handshake; img_out never changes while valid_out=1.
- tready and valid_out are registered; there is no combinational path from ready_in to s_axis_tready.
- A frame is delivered only if exactly N_PIX beats arrive with tlast on the last beat.

Optional Feature:
- Macro: PACKER_PINGPONG_EN.
- Defined:
  - Adds a separate output register. The shift register keeps filling while a frame is pending on the output, so state FULL is replaced by per-buffer full flags.
  - On frame completion, the shift register is copied to img_out if the output is empty or is handshaking in that same cycle; otherwise the shift register holds and tready=0 until the output handshake.
  - The copy then occurs the cycle after the handshake, with valid_out=1 again that cycle.
  - Frame order is preserved. At most 2 frames are held.
- Undefined: single buffer exactly as in Behaviour (tready=0 while valid_out=1).

Test Plan:
1. Good frame: tdata=0..120 (8'h00..8'h78), tlast on beat 121, ready_in=1 → valid_out high 1 cycle after beat 121; img_out[967:960]=8'h00, [15:8]=8'h77, [7:0]=8'h78; frame_cnt 0→1; frame_err never pulses.
2. Backpressure: good frame with ready_in=0 for 20 cycles → valid_out stays 1, img_out constant, tready=0 (no macro). Then ready_in=1 → handshake; tready=1 next cycle; frame_cnt=1.
3. Short frame: tlast on beat 50 → frame_err one pulse, no valid_out. Next good frame of 0xA5s → img_out all 8'hA5, frame_cnt=1.
4. Long frame: 130 beats, tlast on beat 130 → frame_err pulses after beat 121; beats 122–130 accepted and dropped; no valid_out. Following good frame is delivered correctly.
5. Reset mid-frame: rst=0 for one cycle after 60 beats → all outputs at reset values. A fresh 121-beat frame is then delivered intact, frame_cnt=1.
6. PACKER_PINGPONG_EN, ready_in=0: two back-to-back good frames A then B → tready stays 1 through all of B, drops to 0 after B's beat 121. Raise ready_in → A handshakes, then B is presented and handshakes; frame_cnt=2.
